xor8_arbiter: RTL
=================

# xor8_arbiter

Shares a single 8-bit bitwise XOR datapath among up to 8 requesters. Grants one pending request per cycle round-robin, registers `a ^ b` into a one-entry response buffer, and returns the result with the requester's index. Sits between the requesting agents and the shared xor8 unit, which is instantiated inside this block.

## Interface
Parameters:
- `NREQ`, 4: number of requesters. Legal range 2..8.

Ports:
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_valid`, input, NREQ: requester i has an operand pair pending.
- `req_ready`, output, NREQ: one-hot grant. Requester i's pair is consumed when `req_valid[i] & req_ready[i]`.
- `req_a`, input, 8*NREQ: operand A. Requester i uses bits `[8i+7:8i]`.
- `req_b`, input, 8*NREQ: operand B. Same slicing as `req_a`.
- `rsp_valid`, output, 1: the response buffer holds a result.
- `rsp_ready`, input, 1: downstream accepts the response.
- `rsp_data`, output, 8: registered `a ^ b` of the granted pair.
- `rsp_id`, output, 3: index of the requester that produced `rsp_data`.
- `busy`, output, 1: `rsp_valid | (|req_valid)`.

## Operation
- Response buffer has two states:
  - EMPTY: `rsp_valid=0`.
  - FULL: `rsp_valid=1`.
- `can_accept = !rsp_valid | rsp_ready`.
- Grant rule:
  - When `can_accept`, the lowest index i at or after `rr_ptr` (wrapping modulo NREQ) with `req_valid[i]=1` gets `req_ready[i]=1`.
  - All other `req_ready` bits are 0.
  - When `!can_accept`, `req_ready` is all 0.
- `req_ready` is combinational from `req_valid`, `rr_ptr`, `rsp_valid` and `rsp_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- On a grant to i:
  - Buffer loads `rsp_data <= req_a[i] ^ req_b[i]` and `rsp_id <= i`.
  - State becomes FULL.
  - `rr_ptr <= (i == NREQ-1) ? 0 : i+1`.
- FULL with `rsp_ready=1` and no grant: state becomes EMPTY. `rsp_data` and `rsp_id` hold their last values.
- FULL with `rsp_ready=1` and a grant in the same cycle: drain and refill. State stays FULL with the new data.
- FULL with `rsp_ready=0`: `rsp_data` and `rsp_id` are held stable and no grant is issued.
- `rr_ptr` changes only on a grant. It is 3 bits wide and always less than NREQ.
- Request lines with index ≥ NREQ do not exist. `rsp_id` upper bits are 0 when NREQ ≤ 4.

## Timing
- Reset values: `rsp_valid=0`, `rsp_data=8'h00`, `rsp_id=3'd0`, `rr_ptr=0`.
- `req_ready` is all 0 in any cycle where `rst=1`, regardless of `req_valid`.
- Reset asserted while FULL discards the held response. `rsp_valid=0` in the cycle after the reset edge.
- Latency: a pair accepted at edge k appears on `rsp_data` with `rsp_valid=1` in the cycle after edge k, i.e. 1 cycle.
- Throughput: 1 result per cycle while `rsp_ready` is held at 1 and any request is pending.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once in every NREQ consecutive grants.

## Configuration
- `XOR8_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority. The lowest index with `req_valid=1` always wins. `rr_ptr` stays at 0 and its update logic is compiled out.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Reset:
  - Stimulus: assert `rst` with `req_valid=4'b1111`.
  - Response: `req_ready=0`, `rsp_valid=0`, `rsp_data=8'h00`, `rsp_id=0`.
  - Stimulus: release `rst`.
  - Response: first grant goes to requester 0.
- Single request:
  - Stimulus: requester 2 valid with a=8'hA5, b=8'h0F, and `rsp_ready=1`.
  - Response: `req_ready=4'b0100` that cycle. Next cycle `rsp_valid=1`, `rsp_data=8'hAA`, `rsp_id=2`.
- Round-robin:
  - Stimulus: all 4 requesters valid continuously, `rsp_ready=1`.
  - Response: `rsp_id` sequence 0,1,2,3,0,1, one result per cycle.
  - Stimulus: repeat with `XOR8_ARB_FIXED_PRIO_EN` defined.
  - Response: `rsp_id` constant 0.
- Backpressure:
  - Stimulus: `rsp_ready=0` for 5 cycles while FULL with `rsp_data=8'h3C`, `rsp_id=1`, requester 3 valid.
  - Response: `req_ready=0` and outputs stable for 5 cycles. Then `rsp_ready=1` gives drain and refill in one cycle, and requester 3's result appears next cycle.
- Drain without refill:
  - Stimulus: FULL, `rsp_ready=1`, no `req_valid`.
  - Response: `rsp_valid=0` next cycle. `busy` goes to 0.
- Reset mid-operation:
  - Stimulus: assert `rst` while FULL with `rr_ptr=2`.
  - Response: `rsp_valid=0` next cycle. `rr_ptr=0`, so the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/xor8_arbiter.sv
// xor8_arbiter
//   Shares one 8-bit XOR datapath among NREQ requesters. One pending request is
//   granted per cycle (round-robin by default) when the one-entry response
//   buffer can accept. The result a^b is registered together with the index of
//   the requester that produced it.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   req_valid[NREQ]   : requester i has an operand pair pending
//   req_ready[NREQ]   : one-hot grant (combinational)
//   req_a/req_b       : operands, requester i uses [8i+7:8i]
//   rsp_valid         : response buffer full
//   rsp_ready         : downstream accepts response
//   rsp_data, rsp_id  : registered a^b and producing requester index
//   busy              : rsp_valid | (|req_valid)
//
// Configuration
//   XOR8_ARB_FIXED_PRIO_EN : when defined, lowest valid index always wins and
//                            the round-robin pointer is tied to 0.

module xor8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] y
);
   assign y = a ^ b;
endmodule

module xor8_arbiter #(
   parameter int NREQ = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [8*NREQ-1:0]   req_a,
   input  logic [8*NREQ-1:0]   req_b,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [7:0]          rsp_data,
   output logic [2:0]          rsp_id,
   output logic                busy
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t            state;
   logic [2:0]        rr_ptr;
   logic              can_accept;
   logic              gnt_any;
   logic [2:0]        gnt_idx;
   logic [NREQ-1:0]   gnt;
   logic [7:0]        op_a, op_b, xor_y;

   assign rsp_valid  = (state == FULL);
   assign can_accept = !rsp_valid | rsp_ready;
   assign busy       = rsp_valid | (|req_valid);
   assign req_ready  = gnt;

   // Two-pass scan: first indices at/after rr_ptr, then the wrapped ones below
   // it. The first hit wins, which yields the lowest index modulo NREQ starting
   // at rr_ptr. The operand mux for the shared XOR unit rides along.
   always_comb begin
      gnt     = '0;
      gnt_any = 1'b0;
      gnt_idx = 3'd0;
      op_a    = 8'h00;
      op_b    = 8'h00;
      if (!rst && can_accept) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any && req_valid[i] && (3'(i) >= rr_ptr)) begin
               gnt_any = 1'b1;
               gnt_idx = 3'(i);
               gnt[i]  = 1'b1;
               op_a    = req_a[8*i +: 8];
               op_b    = req_b[8*i +: 8];
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any && req_valid[i] && (3'(i) < rr_ptr)) begin
               gnt_any = 1'b1;
               gnt_idx = 3'(i);
               gnt[i]  = 1'b1;
               op_a    = req_a[8*i +: 8];
               op_b    = req_b[8*i +: 8];
            end
         end
      end
   end

   xor8 u_xor8 (
      .a (op_a),
      .b (op_b),
      .y (xor_y)
   );

   // Response buffer. A grant always (re)fills; draining without a grant
   // empties but leaves data/id untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= EMPTY;
         rsp_data <= 8'h00;
         rsp_id   <= 3'd0;
      end else if (gnt_any) begin
         state    <= FULL;
         rsp_data <= xor_y;
         rsp_id   <= gnt_idx;
      end else if (rsp_ready) begin
         state    <= EMPTY;
      end
   end

`ifdef XOR8_ARB_FIXED_PRIO_EN
   assign rr_ptr = 3'd0;
`else
   // Pointer moves only on a grant, to the slot just past the winner.
   always_ff @(posedge clk) begin
      if (rst)
         rr_ptr <= 3'd0;
      else if (gnt_any)
         rr_ptr <= (gnt_idx == 3'(NREQ-1)) ? 3'd0 : gnt_idx + 3'd1;
   end
`endif

endmodule
